alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_iter.sv | 60 ++++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   op_t    : 3-bit opcode (values 101..111 are reserved and flagged illegal)
//   state_t : control FSM states of alu_seq
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_MUL = 3'b100
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MUL_RUN = 2'd1,
      S_DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned WIDTH x WIDTH iterative shift-add multiplier.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a multiply; operands are read in the following cycles
//   mcand, mplier : operands, must stay stable while busy
//   busy          : iterations in progress
//   done          : one-cycle pulse, prod holds the final product
//   prod          : 2*WIDTH-bit product accumulator
// One partial product per cycle, selected by the WIDTH-bit iteration counter:
// exactly WIDTH iterations, done pulses the cycle after the last one.
module alu_mul_iter #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

   logic [WIDTH-1:0]   cnt;
   logic [WIDTH-1:0]   bsh;
   logic [2*WIDTH-1:0] pp;

   // partial product for bit cnt of the multiplier
   always_comb begin
      bsh = mplier >> cnt;
      pp  = '0;
      if (bsh[0])
         pp = {{WIDTH{1'b0}}, mcand} << cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         prod <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            cnt  <= '0;
            prod <= '0;
            busy <= 1'b1;
         end else if (busy) begin
            prod <= prod + pp;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: one-operation-at-a-time ALU with valid/ready handshakes.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operation offered / accepted (ready only in IDLE)
//   a, b, op             : operands and opcode (see alu_pkg::op_t)
//   out_valid/out_ready  : result offered / taken by consumer
//   result, result_hi    : low result, upper product half (MUL only, else 0)
//   overflow, zero, illegal : status flags, held with the result
// ADD/SUB/AND/OR/reserved finish in one cycle; MUL runs WIDTH iterations in
// alu_mul_iter. All outputs are registered and hold while DONE is stalled.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             overflow,
   output logic             zero,
   output logic             illegal
);

   state_t             state;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               accept;
   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [WIDTH-1:0]   sum, diff, c_res;
   logic               c_ovf, c_ill;

   // in_ready is a register that tracks state==IDLE exactly
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL);

   // single-cycle ops, evaluated on the live inputs at acceptance
   always_comb begin
      sum   = a + b;
      diff  = a - b;
      c_res = '0;
      c_ovf = 1'b0;
      c_ill = 1'b0;
      case (op_t'(op))
         OP_ADD: begin
            c_res = sum;
            c_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            c_res = diff;
            c_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  c_res = a & b;
         OP_OR:   c_res = a | b;
         OP_MUL:  c_res = '0;
         default: c_ill = 1'b1;
      endcase
   end

   // multiplier works on the captured operands, so input changes while it
   // runs cannot leak into the product
   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .mcand  (a_q),
      .mplier (b_q),
      .busy   (mul_busy),
      .done   (mul_done),
      .prod   (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         a_q       <= '0;
         b_q       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_q      <= a;
                  b_q      <= b;
                  in_ready <= 1'b0;
                  if (op == OP_MUL) begin
                     state <= S_MUL_RUN;
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     result    <= c_res;
                     result_hi <= '0;
                     overflow  <= c_ovf;
                     zero      <= (c_res == '0);
                     illegal   <= c_ill;
                  end
               end
            end
            S_MUL_RUN: begin
               if (mul_done && !mul_busy) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  result    <= mul_prod[WIDTH-1:0];
                  result_hi <= mul_prod[2*WIDTH-1:WIDTH];
                  overflow  <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                  zero      <= (mul_prod[WIDTH-1:0] == '0);
                  illegal   <= 1'b0;
               end
            end
            S_DONE: begin
               // back to IDLE only; the next op can be taken a cycle later
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=4) with hand-computed
// expectations. Inputs change and outputs are sampled 1 time unit after the
// rising edge.
module tb_alu_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, result, result_hi;
   logic [2:0]   op;
   logic         overflow, zero, illegal;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .overflow  (overflow),
      .zero      (zero),
      .illegal   (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // offer one op for a single accept edge, leave out_ready as set
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // check outputs of a completed op: {valid, result, hi, ovf, zero, ill}
   task automatic chk_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] h,
                          input logic ov, input logic z, input logic il);
      chk({tag, ".valid"}, out_valid, 1);
      chk({tag, ".res"},   result, r);
      chk({tag, ".hi"},    result_hi, h);
      chk({tag, ".ovf"},   overflow, ov);
      chk({tag, ".zero"},  zero, z);
      chk({tag, ".ill"},   illegal, il);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      chk({tag, ".idle_valid"}, out_valid, 0);
      chk({tag, ".idle_ready"}, in_ready, 1);
   endtask

   initial begin
      logic saw_valid;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; op = 3'b000;
      step(); step();
      rst = 1'b0;
      chk("rst.in_ready", in_ready, 1);
      chk("rst.valid",    out_valid, 0);
      chk("rst.res",      result, 0);
      chk("rst.hi",       result_hi, 0);
      chk("rst.flags",    {overflow, zero, illegal}, 0);

      // ADD 6+7 = 13, signed overflow; in_valid kept high into the DONE
      // release cycle must not start a second op
      issue(3'b000, 4'b0110, 4'b0111);
      chk_out("add", 4'b1101, 4'b0000, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("add.no_accept_valid", out_valid, 0);
      chk("add.no_accept_ready", in_ready, 1);
      in_valid = 1'b0;

      issue(3'b001, 4'b0011, 4'b0011);
      chk_out("sub0", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
      drain("sub0");
      issue(3'b001, 4'b0010, 4'b0011);
      chk_out("subneg", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      drain("subneg");
      issue(3'b010, 4'b1100, 4'b1010);
      chk_out("and", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
      drain("and");

      // MUL 5*7 = 35 = 0010_0011, valid exactly 5 cycles after accept;
      // garbage inputs during the run must be ignored
      out_ready = 1'b0;
      issue(3'b100, 4'b0101, 4'b0111);
      a = 4'b1111; b = 4'b1111; op = 3'b000; in_valid = 1'b1;
      chk("mul.c0.valid", out_valid, 0);
      chk("mul.c0.ready", in_ready, 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("mul.c%0d.valid", i), out_valid, 0);
         chk($sformatf("mul.c%0d.ready", i), in_ready, 0);
      end
      step();
      chk_out("mul", 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
      chk("mul.ready", in_ready, 0);
      // back-pressure: held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out($sformatf("hold%0d", i), 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      drain("mul");

      // reset on the 2nd MUL_RUN cycle abandons the multiply
      issue(3'b100, 4'b0011, 4'b0011);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst.valid", out_valid, 0);
      chk("mrst.res",   result, 0);
      chk("mrst.hi",    result_hi, 0);
      chk("mrst.flags", {overflow, zero, illegal}, 0);
      chk("mrst.ready", in_ready, 1);
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         saw_valid |= out_valid;
      end
      chk("mrst.never_valid", saw_valid, 0);
      issue(3'b000, 4'b0001, 4'b0001);
      chk_out("mrst.add", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
      drain("mrst.add");

      // reserved op, then OR clears illegal
      issue(3'b111, 4'b1010, 4'b0110);
      chk_out("rsv", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
      drain("rsv");
      issue(3'b011, 4'b1010, 4'b0101);
      chk_out("or", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      drain("or");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
